rally_sequencer: RTL and testbench
==================================

Name: rally_sequencer

Overview:
- Game-flow controller for the square's motion path. It sequences startup, serve delay, rally, miss pause and game over.
- Drives the velocity mapper's control inputs: game_startup, sq_missed, game_over and the clamped hit_y magnitude.
- Owns the square's direction bits and both players' scores.
- Sits between the collision/bounds detector and the velocity mapper / square position integrator.

Parameters:
WIN_SCORE, 9, score at which a game ends (1..15)
SERVE_FRAMES, 60, frame ticks the square waits stationary before a serve (>=1)
MISS_FRAMES, 30, frame ticks of pause after a miss (>=1)
PDL_HALF, 48, half paddle height; hit_y clamp ceiling (<=127)

Ports:
clk_0  in  1  25.175MHz pixel clock
rst  in  1  reset, synchronous, active-low
start_btn  in  1  debounced, synchronised start key, active-high level
frame_tick  in  1  one-cycle pulse per video frame
hit_l  in  1  one-cycle pulse: square touched left paddle
hit_r  in  1  one-cycle pulse: square touched right paddle
hit_dy  in  8  signed two's complement: square centre y minus paddle centre y, valid with hit_l/hit_r
out_l  in  1  one-cycle pulse: square crossed left boundary
out_r  in  1  one-cycle pulse: square crossed right boundary
game_startup  out  1  high in STARTUP
sq_missed  out  1  high in SERVE and MISS (forces minimum velocity)
game_over  out  1  high in OVER
sq_moving  out  1  high in RALLY; enables position integration
hit_y  out  7  clamped |hit_dy| of the last accepted hit
sq_xdir  out  1  1 = moving right, 0 = moving left
sq_ydir  out  1  1 = moving down, 0 = moving up
score_l  out  4  left player score
score_r  out  4  right player score

Behaviour:
- All outputs are registered and update the cycle after the triggering input is sampled.
- Exactly one of game_startup, sq_missed, game_over, sq_moving is high at any time.
- Reset (rst low at a clk_0 edge):
  - state = STARTUP; game_startup = 1; other flags 0.
  - hit_y = 0; sq_xdir = 1; sq_ydir = 1; scores = 0; frame counter = 0; start edge register = 0.
  - Reset overrides everything, including mid-rally and mid-count.
- start_btn edge: detected with a one-register rising-edge detector. A held button triggers only once.
- STARTUP:
  - On a start rising edge -> SERVE, with scores cleared, counter = 0 and hit_y = 0.
  - All other inputs are ignored.
- SERVE:
  - The counter increments on each frame_tick.
  - On the tick where counter == SERVE_FRAMES-1 -> RALLY, counter cleared.
  - hit/out pulses are ignored.
- RALLY:
  - hit_l is accepted only when sq_xdir == 0. On acceptance:
    - sq_xdir <= 1.
    - hit_y <= min(|hit_dy|, PDL_HALF). hit_dy = -128 clamps to PDL_HALF.
    - sq_ydir <= 0 if hit_dy < 0; 1 if hit_dy > 0; unchanged if 0.
  - hit_r is accepted only when sq_xdir == 1; same handling with sq_xdir <= 0.
  - Wrong-direction hits are ignored (prevents double bounce while overlapping the paddle).
  - hit_l and hit_r in the same cycle: only the direction-valid one is accepted.
  - out_l -> score_r += 1 (saturating at WIN_SCORE), sq_xdir <= 1, hit_y <= 0, -> MISS.
  - out_r -> score_l += 1 (saturating), sq_xdir <= 0, hit_y <= 0, -> MISS.
  - The serve therefore goes toward the player who scored.
  - out_l and out_r in the same cycle: out_l wins.
  - out_x and hit_x in the same cycle: out wins and the hit is discarded.
- MISS:
  - The counter counts frame_ticks; on the tick where counter == MISS_FRAMES-1 it clears.
  - Then -> OVER if score_l == WIN_SCORE or score_r == WIN_SCORE, else -> SERVE.
- OVER:
  - Scores hold for display.
  - On a start rising edge -> SERVE with scores cleared, counter 0, sq_xdir = 1, sq_ydir = 1.
- Counter: 8 bits wide; SERVE_FRAMES and MISS_FRAMES are limited to <= 256.
- frame_tick in the same cycle as a state entry does not count toward the new state.

Test Plan:
- Reset, then pulse start_btn high 1 cycle -> game_startup falls and sq_missed rises next cycle; scores 0. After exactly 60 frame_ticks, sq_moving = 1 and sq_xdir = 1.
- In RALLY with sq_xdir = 1: hit_r with hit_dy = -20 -> sq_xdir = 0, sq_ydir = 0, hit_y = 20. A repeat hit_r the next cycle is ignored.
- In RALLY: hit_l with hit_dy = +100 -> hit_y = 48, sq_ydir = 1. With hit_dy = -128 -> hit_y = 48. With hit_dy = 0 -> sq_ydir unchanged, hit_y = 0.
- In RALLY: out_r and hit_r in the same cycle -> score_l = 1, sq_xdir = 0, sq_missed = 1. After 30 frame_ticks -> SERVE; after a further 60 ticks -> RALLY.
- Score_r at 8, then out_l -> score_r = 9. After 30 ticks game_over = 1. Holding start_btn high for 100 cycles gives one transition to SERVE with scores 0.
- Assert rst low mid-MISS on a frame_tick -> next cycle game_startup = 1, scores 0, hit_y = 0. Start edge-detector cleared, so an already-high start_btn does not trigger until it is released and pressed again.

Source files
------------

// File: rtl/rally_sequencer.sv
// rally_sequencer
//   Game-flow controller for the square's motion path: sequences startup,
//   serve delay, rally, miss pause and game over. Owns the square's direction
//   bits and both players' scores. It feeds the velocity mapper and the
//   position integrator.
//
// Ports
//   clk_0        pixel clock
//   rst          synchronous, active-low reset
//   start_btn    debounced start key (level); acts on its rising edge
//   frame_tick   one-cycle pulse per video frame
//   hit_l/hit_r  one-cycle paddle contact pulses
//   hit_dy       signed square-centre minus paddle-centre y, valid with a hit
//   out_l/out_r  one-cycle boundary-crossing pulses
//   game_startup high in STARTUP
//   sq_missed    high in SERVE and MISS
//   game_over    high in OVER
//   sq_moving    high in RALLY
//   hit_y        clamped |hit_dy| of the last accepted hit
//   sq_xdir      1 = right, 0 = left
//   sq_ydir      1 = down,  0 = up
//   score_l/r    player scores
module rally_sequencer #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned MISS_FRAMES  = 30,
  parameter int unsigned PDL_HALF     = 48
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic       hit_l,
  input  logic       hit_r,
  input  logic [7:0] hit_dy,
  input  logic       out_l,
  input  logic       out_r,
  output logic       game_startup,
  output logic       sq_missed,
  output logic       game_over,
  output logic       sq_moving,
  output logic [6:0] hit_y,
  output logic       sq_xdir,
  output logic       sq_ydir,
  output logic [3:0] score_l,
  output logic [3:0] score_r
);

  typedef enum logic [2:0] {
    ST_STARTUP,
    ST_SERVE,
    ST_RALLY,
    ST_MISS,
    ST_OVER
  } state_t;

  localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
  localparam logic [7:0] MISS_LAST  = 8'(MISS_FRAMES - 1);
  localparam logic [3:0] WIN        = 4'(WIN_SCORE);
  localparam logic [7:0] CLAMP8     = 8'(PDL_HALF);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [6:0]  hit_y_q, hit_y_d;
  logic        xdir_q, xdir_d;
  logic        ydir_q, ydir_d;
  logic [3:0]  score_l_q, score_l_d;
  logic [3:0]  score_r_q, score_r_d;
  logic        start_q;
  logic [3:0]  flags_q, flags_d;

  logic        start_rise;
  logic [7:0]  mag;
  logic [6:0]  clamp;
  logic        hit_ok;

  // -128 negates to 8'h80 = 128 unsigned, which the clamp then limits.
  assign mag   = hit_dy[7] ? (~hit_dy + 8'd1) : hit_dy;
  assign clamp = (mag > CLAMP8) ? CLAMP8[6:0] : mag[6:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    hit_y_d    = hit_y_q;
    xdir_d     = xdir_q;
    ydir_d     = ydir_q;
    score_l_d  = score_l_q;
    score_r_d  = score_r_q;
    start_rise = start_btn & ~start_q;
    hit_ok     = 1'b0;

    unique case (state_q)
      ST_STARTUP: begin
        if (start_rise) begin
          state_d   = ST_SERVE;
          score_l_d = '0;
          score_r_d = '0;
          cnt_d     = '0;
          hit_y_d   = '0;
        end
      end
      ST_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) begin
            state_d = ST_RALLY;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_RALLY: begin
        // Priority: out_l, out_r, then the single direction-valid hit.
        if (out_l) begin
          score_r_d = (score_r_q == WIN) ? score_r_q : score_r_q + 4'd1;
          xdir_d    = 1'b1;
          hit_y_d   = '0;
          state_d   = ST_MISS;
        end else if (out_r) begin
          score_l_d = (score_l_q == WIN) ? score_l_q : score_l_q + 4'd1;
          xdir_d    = 1'b0;
          hit_y_d   = '0;
          state_d   = ST_MISS;
        end else if (hit_l && !xdir_q) begin
          xdir_d = 1'b1;
          hit_ok = 1'b1;
        end else if (hit_r && xdir_q) begin
          xdir_d = 1'b0;
          hit_ok = 1'b1;
        end
        if (hit_ok) begin
          hit_y_d = clamp;
          if (hit_dy[7]) begin
            ydir_d = 1'b0;
          end else if (hit_dy != 8'd0) begin
            ydir_d = 1'b1;
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (cnt_q == MISS_LAST) begin
            cnt_d   = '0;
            state_d = (score_l_q == WIN || score_r_q == WIN) ? ST_OVER : ST_SERVE;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      ST_OVER: begin
        if (start_rise) begin
          state_d   = ST_SERVE;
          score_l_d = '0;
          score_r_d = '0;
          cnt_d     = '0;
          xdir_d    = 1'b1;
          ydir_d    = 1'b1;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    // Flags are registered from the next state so they change together with it.
    flags_d = {state_d == ST_STARTUP,
               state_d == ST_SERVE || state_d == ST_MISS,
               state_d == ST_OVER,
               state_d == ST_RALLY};
  end

  always_ff @(posedge clk_0) begin
    if (!rst) begin
      state_q   <= ST_STARTUP;
      cnt_q     <= '0;
      hit_y_q   <= '0;
      xdir_q    <= 1'b1;
      ydir_q    <= 1'b1;
      score_l_q <= '0;
      score_r_q <= '0;
      start_q   <= 1'b0;
      flags_q   <= 4'b1000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hit_y_q   <= hit_y_d;
      xdir_q    <= xdir_d;
      ydir_q    <= ydir_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
      start_q   <= start_btn;
      flags_q   <= flags_d;
    end
  end

  assign {game_startup, sq_missed, game_over, sq_moving} = flags_q;
  assign hit_y   = hit_y_q;
  assign sq_xdir = xdir_q;
  assign sq_ydir = ydir_q;
  assign score_l = score_l_q;
  assign score_r = score_r_q;

endmodule

// File: tb/tb_rally_sequencer.sv
// Testbench for rally_sequencer: directed game scenarios followed by random
// stimulus, every cycle compared against a behavioural game model.
module tb_rally_sequencer;

  localparam int WIN   = 9;
  localparam int SERVE = 60;
  localparam int MISS  = 30;
  localparam int PDL   = 48;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b0, start_btn = 1'b0, frame_tick = 1'b0;
  logic       hit_l = 1'b0, hit_r = 1'b0, out_l = 1'b0, out_r = 1'b0;
  logic [7:0] hit_dy = '0;
  logic       game_startup, sq_missed, game_over, sq_moving, sq_xdir, sq_ydir;
  logic [6:0] hit_y;
  logic [3:0] score_l, score_r;

  int errors = 0;
  int checks = 0;

  rally_sequencer #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SERVE), .MISS_FRAMES(MISS), .PDL_HALF(PDL)
  ) dut (
    .clk_0(clk_0), .rst(rst), .start_btn(start_btn), .frame_tick(frame_tick),
    .hit_l(hit_l), .hit_r(hit_r), .hit_dy(hit_dy), .out_l(out_l), .out_r(out_r),
    .game_startup(game_startup), .sq_missed(sq_missed), .game_over(game_over),
    .sq_moving(sq_moving), .hit_y(hit_y), .sq_xdir(sq_xdir), .sq_ydir(sq_ydir),
    .score_l(score_l), .score_r(score_r)
  );

  always #5 clk_0 = ~clk_0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Game model: phase names 0 idle-before-first-game, 1 waiting to serve,
  // 2 ball in play, 3 pause after a point, 4 game finished.
  int m_ph, m_cnt, m_hy, m_xd, m_yd, m_sl, m_sr, m_sp;

  task automatic model(input logic r, s, ft, hl, hr, ol, o_r, input logic [7:0] dy);
    int d, a;
    bit rise;
    if (!r) begin
      m_ph = 0; m_cnt = 0; m_hy = 0; m_xd = 1; m_yd = 1; m_sl = 0; m_sr = 0; m_sp = 0;
      return;
    end
    rise = s && !m_sp;
    m_sp = s;
    d = $signed(dy);
    a = (d < 0) ? -d : d;
    case (m_ph)
      0: if (rise) begin m_ph = 1; m_sl = 0; m_sr = 0; m_cnt = 0; m_hy = 0; end
      1: if (ft) begin
           m_cnt++;
           if (m_cnt == SERVE) begin m_ph = 2; m_cnt = 0; end
         end
      2: begin
           if (ol) begin
             if (m_sr < WIN) m_sr++;
             m_xd = 1; m_hy = 0; m_ph = 3;
           end else if (o_r) begin
             if (m_sl < WIN) m_sl++;
             m_xd = 0; m_hy = 0; m_ph = 3;
           end else if ((hl && m_xd == 0) || (hr && m_xd == 1)) begin
             m_xd = 1 - m_xd;
             m_hy = (a > PDL) ? PDL : a;
             if (d < 0) m_yd = 0;
             else if (d > 0) m_yd = 1;
           end
         end
      3: if (ft) begin
           m_cnt++;
           if (m_cnt == MISS) begin
             m_cnt = 0;
             m_ph = (m_sl == WIN || m_sr == WIN) ? 4 : 1;
           end
         end
      default: if (rise) begin
           m_ph = 1; m_sl = 0; m_sr = 0; m_cnt = 0; m_xd = 1; m_yd = 1;
         end
    endcase
  endtask

  function automatic logic [31:0] mvec();
    logic [6:0] hy7 = 7'(m_hy);
    logic [3:0] sl4 = 4'(m_sl);
    logic [3:0] sr4 = 4'(m_sr);
    return {11'd0, m_ph == 0, (m_ph == 1 || m_ph == 3), m_ph == 4, m_ph == 2,
            hy7, m_xd[0], m_yd[0], sl4, sr4};
  endfunction

  function automatic logic [31:0] dvec();
    return {11'd0, game_startup, sq_missed, game_over, sq_moving,
            hit_y, sq_xdir, sq_ydir, score_l, score_r};
  endfunction

  // One clock: drive at the falling edge, model after the rising edge,
  // compare at the next falling edge.
  task automatic step(input logic r, s, ft, hl, hr, ol, o_r, input logic [7:0] dy);
    rst = r; start_btn = s; frame_tick = ft; hit_l = hl; hit_r = hr;
    out_l = ol; out_r = o_r; hit_dy = dy;
    @(posedge clk_0);
    model(r, s, ft, hl, hr, ol, o_r, dy);
    @(negedge clk_0);
    chk("outputs", dvec(), mvec());
  endtask

  task automatic idle(input logic s);
    step(1, s, 0, 0, 0, 0, 0, 8'd0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      step(1, 0, 1, 0, 0, 0, 0, 8'd0);
      idle(0);
    end
  endtask

  initial begin
    logic s_r;
    int   sel;
    logic [7:0] dy;
    @(negedge clk_0);

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0, 8'd0);
    step(0, 0, 1, 1, 1, 1, 1, 8'd0);
    chk("rst_startup", {game_startup, sq_missed, game_over, sq_moving}, 4'b1000);
    chk("rst_dirs", {sq_xdir, sq_ydir, hit_y}, {2'b11, 7'd0});

    // Start press -> serve, then 60 ticks -> rally
    idle(1);
    chk("start_serve", {game_startup, sq_missed}, 2'b01);
    idle(0);
    ticks(SERVE - 1);
    chk("serve_59", sq_missed, 1);
    ticks(1);
    chk("serve_done", {sq_moving, sq_xdir}, 2'b11);

    // Paddle hits and clamp
    step(1, 0, 0, 0, 1, 0, 0, 8'hEC);            // -20
    chk("hit_r", {sq_xdir, sq_ydir, hit_y}, {2'b00, 7'd20});
    step(1, 0, 0, 0, 1, 0, 0, 8'd5);             // repeat, wrong direction
    chk("hit_r_rpt", {sq_xdir, sq_ydir, hit_y}, {2'b00, 7'd20});
    step(1, 0, 0, 1, 0, 0, 0, 8'd100);
    chk("hit_l_clamp", {sq_ydir, hit_y}, {1'b1, 7'd48});
    step(1, 0, 0, 0, 1, 0, 0, 8'd1);
    step(1, 0, 0, 1, 0, 0, 0, 8'h80);            // -128
    chk("hit_l_m128", {sq_ydir, hit_y}, {1'b0, 7'd48});
    step(1, 0, 0, 1, 1, 0, 0, 8'd3);             // both hits: hit_r valid
    chk("hit_both", {sq_xdir, hit_y}, {1'b0, 7'd3});
    step(1, 0, 0, 1, 0, 0, 0, 8'd0);
    chk("hit_zero", {sq_ydir, hit_y}, {1'b1, 7'd0});

    // Out beats hit; miss pause then serve then rally
    step(1, 0, 0, 0, 1, 0, 1, 8'd7);
    chk("out_r", {score_l, sq_xdir, sq_missed, hit_y}, {4'd1, 2'b01, 7'd0});
    ticks(MISS);
    chk("miss_to_serve", sq_missed, 1);
    ticks(SERVE);
    chk("serve_to_rally", sq_moving, 1);

    // Right player wins
    for (int p = 0; p < WIN; p++) begin
      step(1, 0, 0, 0, 0, 1, 1, 8'd0);
      ticks(MISS);
      if (p < WIN - 1) ticks(SERVE);
    end
    chk("win", {score_r, game_over}, {4'd9, 1'b1});

    // Held start: one restart only
    for (int i = 0; i < 100; i++) idle(1);
    chk("restart", {sq_missed, score_l, score_r, sq_xdir, sq_ydir}, {1'b1, 8'd0, 2'b11});
    idle(0);

    // Reset mid-miss on a frame tick
    ticks(SERVE);
    step(1, 0, 0, 0, 0, 1, 0, 8'd0);
    ticks(10);
    step(0, 0, 1, 0, 0, 0, 0, 8'd0);
    chk("rst_mid", {game_startup, score_l, score_r, hit_y}, {1'b1, 8'd0, 7'd0});
    idle(0);
    idle(1);
    chk("start_after_rst", sq_missed, 1);

    // Random play
    s_r = 1'b0;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom_range(49) == 0) s_r = ~s_r;
      sel = int'($urandom_range(15));
      case (sel)
        0: dy = 8'h80;
        1: dy = 8'd0;
        2: dy = 8'd127;
        3: dy = 8'hFF;
        default: dy = 8'($urandom);
      endcase
      step($urandom_range(1999) != 0, s_r, $urandom_range(2) == 0,
           $urandom_range(7) == 0, $urandom_range(7) == 0,
           $urandom_range(59) == 0, $urandom_range(59) == 0, dy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
